// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_ctrl
// Purpose  : Command-driven single-port RAM controller. Each accepted input
//            word carries a 2-bit command and a payload. The commands load
//            the write address, write data, load the read address and read
//            data. Bad commands produce a one-cycle err pulse.
// Ports    : clk      - sole clock, all logic on posedge
//            rst      - asynchronous active-high reset
//            din      - {cmd[1:0], payload[PAY_W-1:0]}
//            rx_valid - din qualifier, one command per cycle when high
//            dout     - registered read data, held while tx_valid is low
//            tx_valid - one-cycle strobe marking a fresh dout word
//            err      - one-cycle strobe for a protocol or range error
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl #(
   parameter int PAY_W     = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PAY_W+1:0] din,
   input  logic             rx_valid,
   output logic [PAY_W-1:0] dout,
   output logic             tx_valid,
   output logic             err
);

   localparam logic [1:0]       c_cmd_wa   = 2'b00;
   localparam logic [1:0]       c_cmd_wd   = 2'b01;
   localparam logic [1:0]       c_cmd_ra   = 2'b10;
   localparam logic [1:0]       c_cmd_rd   = 2'b11;
   // One extra bit so that MEM_DEPTH == 2**PAY_W is representable.
   localparam logic [PAY_W:0]   c_depth    = (PAY_W+1)'(MEM_DEPTH);
   localparam logic [PAY_W-1:0] c_last     = PAY_W'(MEM_DEPTH - 1);
   localparam logic [PAY_W-1:0] c_one      = PAY_W'(1);

   logic [PAY_W-1:0] mem_q [0:MEM_DEPTH-1];

   logic [PAY_W-1:0] wr_addr_q, wr_addr_d;
   logic [PAY_W-1:0] rd_addr_q, rd_addr_d;
   logic             wa_vld_q,  wa_vld_d;
   logic             ra_vld_q,  ra_vld_d;
   logic [PAY_W-1:0] dout_q,    dout_d;
   logic             tx_valid_q, tx_valid_d;
   logic             err_q,     err_d;

   logic [1:0]       w_cmd;
   logic [PAY_W-1:0] w_pay;
   logic             w_in_range;
   logic             w_mem_we;
   logic [PAY_W-1:0] w_wr_nxt;
   logic [PAY_W-1:0] w_rd_nxt;

   assign w_cmd      = din[PAY_W+1:PAY_W];
   assign w_pay      = din[PAY_W-1:0];
   assign w_in_range = ({1'b0, w_pay} < c_depth);

   // Post-access address update: wrap at the last legal word, or hold.
   generate
      if (AUTO_INC != 0) begin : g_inc_on
         assign w_wr_nxt = (wr_addr_q == c_last) ? '0 : (wr_addr_q + c_one);
         assign w_rd_nxt = (rd_addr_q == c_last) ? '0 : (rd_addr_q + c_one);
      end else begin : g_inc_off
         assign w_wr_nxt = wr_addr_q;
         assign w_rd_nxt = rd_addr_q;
      end
   endgenerate

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      wa_vld_d   = wa_vld_q;
      ra_vld_d   = ra_vld_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      err_d      = 1'b0;
      w_mem_we   = 1'b0;
      if (rx_valid) begin
         case (w_cmd)
            c_cmd_wa: begin
               if (w_in_range) begin
                  wr_addr_d = w_pay;
                  wa_vld_d  = 1'b1;
               end else begin
                  wa_vld_d  = 1'b0;
                  err_d     = 1'b1;
               end
            end
            c_cmd_wd: begin
               if (wa_vld_q) begin
                  w_mem_we  = 1'b1;
                  wr_addr_d = w_wr_nxt;
               end else begin
                  err_d     = 1'b1;
               end
            end
            c_cmd_ra: begin
               if (w_in_range) begin
                  rd_addr_d = w_pay;
                  ra_vld_d  = 1'b1;
               end else begin
                  ra_vld_d  = 1'b0;
                  err_d     = 1'b1;
               end
            end
            default: begin // c_cmd_rd; payload is ignored
               if (ra_vld_q) begin
                  dout_d     = mem_q[rd_addr_q];
                  tx_valid_d = 1'b1;
                  rd_addr_d  = w_rd_nxt;
               end else begin
                  err_d      = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wa_vld_q   <= 1'b0;
         ra_vld_q   <= 1'b0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wa_vld_q   <= wa_vld_d;
         ra_vld_q   <= ra_vld_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
      end
   end

   // Storage is deliberately not reset; a write is blocked while rst is high
   // so a command racing the reset cannot corrupt memory.
   always_ff @(posedge clk) begin
      if (w_mem_we && !rst) begin
         mem_q[wr_addr_q] <= w_pay;
      end
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_ctrl
// Purpose  : Directed self-checking bench for spi_ram_ctrl. Instance u_dut
//            uses default parameters; u_dut2 uses MEM_DEPTH=200, AUTO_INC=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

   localparam logic [1:0] c_wa = 2'b00;
   localparam logic [1:0] c_wd = 2'b01;
   localparam logic [1:0] c_ra = 2'b10;
   localparam logic [1:0] c_rd = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] din1, din2;
   logic       rxv1, rxv2;
   logic [7:0] dout1, dout2;
   logic       tx1, tx2, err1, err2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_ram_ctrl u_dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din1),
      .rx_valid (rxv1),
      .dout     (dout1),
      .tx_valid (tx1),
      .err      (err1)
   );

   spi_ram_ctrl #(.PAY_W(8), .MEM_DEPTH(200), .AUTO_INC(0)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .din      (din2),
      .rx_valid (rxv2),
      .dout     (dout2),
      .tx_valid (tx2),
      .err      (err2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Checks tx_valid, err and dout of the selected instance.
   task automatic obs(input int sel, input string tag, input logic tx, input logic e, input logic [7:0] d);
      if (sel == 0) begin
         check({tag, ".tx"},   32'(tx1),   32'(tx));
         check({tag, ".err"},  32'(err1),  32'(e));
         check({tag, ".dout"}, 32'(dout1), 32'(d));
      end else begin
         check({tag, ".tx"},   32'(tx2),   32'(tx));
         check({tag, ".err"},  32'(err2),  32'(e));
         check({tag, ".dout"}, 32'(dout2), 32'(d));
      end
   endtask

   // Presents one command for one clock edge; returns #1 after that edge.
   task automatic send(input int sel, input logic [1:0] c, input logic [7:0] p);
      if (sel == 0) begin
         din1 = {c, p}; rxv1 = 1'b1; din2 = '0; rxv2 = 1'b0;
      end else begin
         din2 = {c, p}; rxv2 = 1'b1; din1 = '0; rxv1 = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rxv1 = 1'b0;
      rxv2 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      din1 = '0; din2 = '0;
      rxv1 = 1'b0; rxv2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      obs(0, "reset", 1'b0, 1'b0, 8'h00);
      obs(1, "reset2", 1'b0, 1'b0, 8'h00);
      rst = 1'b0;

      // Read-data with no read address
      send(0, c_rd, 8'h00);
      obs(0, "rd_noaddr", 1'b0, 1'b1, 8'h00);
      idle();
      obs(0, "err_pulse_end", 1'b0, 1'b0, 8'h00);

      // Seed mem[0]=0x77, then read it back
      send(0, c_wa, 8'h00);
      obs(0, "wa0", 1'b0, 1'b0, 8'h00);
      send(0, c_wd, 8'h77);
      obs(0, "wd77", 1'b0, 1'b0, 8'h00);
      send(0, c_ra, 8'h00);
      obs(0, "ra0", 1'b0, 1'b0, 8'h00);
      send(0, c_rd, 8'h00);
      obs(0, "rd77", 1'b1, 1'b0, 8'h77);

      // Reset arriving between read-data issue and the clock edge
      din1 = {c_rd, 8'h00};
      rxv1 = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      obs(0, "async_rst", 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      obs(0, "rst_discard", 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      send(0, c_rd, 8'h00);
      obs(0, "post_rst_rd", 1'b0, 1'b1, 8'h00);

      // Write-data without a write address must leave mem[0] alone
      send(0, c_wd, 8'h55);
      obs(0, "wd_noaddr", 1'b0, 1'b1, 8'h00);
      send(0, c_ra, 8'h00);
      send(0, c_rd, 8'h00);
      obs(0, "mem_unchanged", 1'b1, 1'b0, 8'h77);

      // Basic write/read
      send(0, c_wa, 8'h10);
      send(0, c_wd, 8'hA5);
      obs(0, "basic_wd", 1'b0, 1'b0, 8'h77);
      send(0, c_ra, 8'h10);
      obs(0, "basic_ra", 1'b0, 1'b0, 8'h77);
      send(0, c_rd, 8'h00);
      obs(0, "basic_rd", 1'b1, 1'b0, 8'hA5);
      idle();
      obs(0, "basic_hold", 1'b0, 1'b0, 8'hA5);

      // Burst with wrap 0xFE, 0xFF, 0x00
      send(0, c_wa, 8'hFE);
      send(0, c_wd, 8'h11);
      send(0, c_wd, 8'h22);
      send(0, c_wd, 8'h33);
      send(0, c_ra, 8'hFE);
      send(0, c_rd, 8'h00);
      obs(0, "burst0", 1'b1, 1'b0, 8'h11);
      send(0, c_rd, 8'h00);
      obs(0, "burst1", 1'b1, 1'b0, 8'h22);
      send(0, c_rd, 8'h00);
      obs(0, "burst2", 1'b1, 1'b0, 8'h33);
      idle();
      obs(0, "burst_end", 1'b0, 1'b0, 8'h33);
      send(0, c_ra, 8'h00);
      send(0, c_rd, 8'h00);
      obs(0, "wrap_addr0", 1'b1, 1'b0, 8'h33);

      // Read-data the cycle after write-data to the same address
      send(0, c_ra, 8'h40);
      send(0, c_wa, 8'h40);
      send(0, c_wd, 8'h9C);
      send(0, c_rd, 8'h00);
      obs(0, "wr_then_rd", 1'b1, 1'b0, 8'h9C);

      // No-op: rx_valid low with a read-data pattern on din
      send(0, c_ra, 8'h10);
      din1 = {c_rd, 8'h00};
      rxv1 = 1'b0;
      @(posedge clk);
      #1;
      obs(0, "noop", 1'b0, 1'b0, 8'h9C);
      send(0, c_rd, 8'h00);
      obs(0, "noop_state", 1'b1, 1'b0, 8'hA5);

      // Out-of-range addressing, MEM_DEPTH=200, no auto-increment
      send(1, c_wa, 8'hC8);
      obs(1, "oor_wa", 1'b0, 1'b1, 8'h00);
      send(1, c_wd, 8'h12);
      obs(1, "oor_wd", 1'b0, 1'b1, 8'h00);
      send(1, c_wa, 8'hC7);
      obs(1, "last_wa", 1'b0, 1'b0, 8'h00);
      send(1, c_wd, 8'h3C);
      send(1, c_wd, 8'h4D);
      obs(1, "hold_wd", 1'b0, 1'b0, 8'h00);
      send(1, c_ra, 8'hC8);
      obs(1, "oor_ra", 1'b0, 1'b1, 8'h00);
      send(1, c_rd, 8'h00);
      obs(1, "oor_rd", 1'b0, 1'b1, 8'h00);
      send(1, c_ra, 8'hC7);
      send(1, c_rd, 8'h00);
      obs(1, "hold_rd0", 1'b1, 1'b0, 8'h4D);
      send(1, c_rd, 8'h00);
      obs(1, "hold_rd1", 1'b1, 1'b0, 8'h4D);
      idle();
      obs(1, "hold_end", 1'b0, 1'b0, 8'h4D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
